// File: rtl/fetch_stage_if.sv
// Bundle of fetch-stage signals: decode handshake, EX redirect and instruction-memory port.
// The master modport is the fetch stage; the slave side is decode, EX and imem together.
interface fetch_stage_if;
  logic        stall_d;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc_plus4_d;
  logic        valid_d;

  modport master (
    input  stall_d, redirect, redirect_pc, imem_rdata,
    output imem_req, imem_addr, instr_d, pc_d, pc_plus4_d, valid_d
  );

  modport slave (
    output stall_d, redirect, redirect_pc, imem_rdata,
    input  imem_req, imem_addr, instr_d, pc_d, pc_plus4_d, valid_d
  );
endinterface

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch front end: owns the fetch PC, issues imem reads under a credit rule,
// buffers responses in a small prefetch FIFO and presents the head entry to decode.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic          clk,
  input  logic          reset,
  fetch_stage_if.master io_fetch
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [31:0]      r_pcF;
  logic [31:0]      r_reqPc;
  logic             r_inflight;
  logic [31:0]      r_fifoInstr [FIFO_DEPTH];
  logic [31:0]      r_fifoPc    [FIFO_DEPTH];
  logic [PTR_W-1:0] r_rdPtr;
  logic [PTR_W-1:0] r_wrPtr;
  logic [CNT_W-1:0] r_count;

  logic             w_valid;
  logic             w_pop;
  logic             w_push;
  logic             w_req;
  logic [CNT_W:0]   w_occupancy;
  logic [31:0]      w_headInstr;
  logic [31:0]      w_headPc;

  // A request is only issued when the entry it will occupy is guaranteed free, so the FIFO
  // never overflows; a redirect blocks both the pop and the push of its own cycle.
  always_comb begin
    w_valid     = (r_count != '0);
    w_pop       = w_valid && !io_fetch.stall_d && !io_fetch.redirect;
    w_push      = r_inflight && !io_fetch.redirect;
    w_occupancy = {1'b0, r_count} + (CNT_W+1)'(r_inflight) - (CNT_W+1)'(w_pop);
    w_req       = !reset && !io_fetch.redirect
                  && (w_occupancy < (CNT_W+1)'(FIFO_DEPTH));
    w_headInstr = w_valid ? r_fifoInstr[r_rdPtr] : NOP_INSTR;
    w_headPc    = w_valid ? r_fifoPc[r_rdPtr]    : 32'h0000_0000;
  end

  assign io_fetch.imem_req   = w_req;
  assign io_fetch.imem_addr  = r_pcF;
  assign io_fetch.valid_d    = w_valid;
  assign io_fetch.instr_d    = w_headInstr;
  assign io_fetch.pc_d       = w_headPc;
  assign io_fetch.pc_plus4_d = w_headPc + 32'd4;

  // Clearing r_inflight on reset or redirect discards the response due next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pcF      <= RESET_PC;
      r_reqPc    <= 32'h0000_0000;
      r_inflight <= 1'b0;
      r_rdPtr    <= '0;
      r_wrPtr    <= '0;
      r_count    <= '0;
    end else if (io_fetch.redirect) begin
      r_pcF      <= {io_fetch.redirect_pc[31:2], 2'b00};
      r_inflight <= 1'b0;
      r_rdPtr    <= '0;
      r_wrPtr    <= '0;
      r_count    <= '0;
    end else begin
      if (w_req) begin
        r_pcF   <= r_pcF + 32'd4;
        r_reqPc <= r_pcF;
      end
      r_inflight <= w_req;
      if (w_push) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && w_push) begin
      r_fifoInstr[r_wrPtr] <= io_fetch.imem_rdata;
      r_fifoPc[r_wrPtr]    <= r_reqPc;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(w_push && (r_count == CNT_W'(FIFO_DEPTH))));
    end
  end
`endif

endmodule
